// File: rtl/framebuffer_ctrl.sv
// Double-buffered 4-bit framebuffer: the renderer fills the back bank while the display scans
// the front bank; banks swap during vertical blanking once the renderer marks a frame complete.
module framebuffer_ctrl #(
  parameter int unsigned  DISPLAY_WIDTH  = 320,
  parameter int unsigned  DISPLAY_HEIGHT = 240,
  localparam int unsigned H_BITS         = $clog2(DISPLAY_WIDTH),
  localparam int unsigned V_BITS         = $clog2(DISPLAY_HEIGHT),
  localparam int unsigned A_BITS         = $clog2(DISPLAY_WIDTH * DISPLAY_HEIGHT)
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic [H_BITS-1:0] wr_hcount_in,
  input  logic [V_BITS-1:0] wr_vcount_in,
  input  logic [3:0]        wr_color_in,
  input  logic              wr_valid_in,
  input  logic              wr_new_frame_in,
  output logic              wr_ready_out,
  input  logic [H_BITS-1:0] rd_hcount_in,
  input  logic [V_BITS-1:0] rd_vcount_in,
  input  logic              rd_valid_in,
  input  logic              rd_vblank_in,
  output logic [3:0]        rd_color_out,
  output logic              rd_valid_out,
  output logic              front_sel_out,
  output logic [7:0]        frame_count_out,
  output logic              drop_out
);

  localparam int unsigned Depth = DISPLAY_WIDTH * DISPLAY_HEIGHT;

  typedef enum logic {StWrite, StWaitSwap} state_e;

  state_e      state_q, state_d;
  logic        front_q, front_d;
  logic [7:0]  count_q, count_d;
  logic        drop_q, drop_d;

  logic [3:0]  bank0_q [Depth];
  logic [3:0]  bank1_q [Depth];

  logic              wr_in_range, rd_in_range, wr_en;
  logic [A_BITS-1:0] wr_addr, rd_addr;

  logic        rd_valid_q1, rd_valid_q2;
  logic [3:0]  rd_data_q1, rd_color_q2;

  // Range is checked on the coordinates, so the address only has to be exact when in range.
  assign wr_in_range = (32'(wr_hcount_in) < DISPLAY_WIDTH) && (32'(wr_vcount_in) < DISPLAY_HEIGHT);
  assign rd_in_range = (32'(rd_hcount_in) < DISPLAY_WIDTH) && (32'(rd_vcount_in) < DISPLAY_HEIGHT);
  assign wr_addr = A_BITS'(wr_vcount_in) * A_BITS'(DISPLAY_WIDTH) + A_BITS'(wr_hcount_in);
  assign rd_addr = A_BITS'(rd_vcount_in) * A_BITS'(DISPLAY_WIDTH) + A_BITS'(rd_hcount_in);

  assign wr_en = !rst_in && wr_valid_in && (state_q == StWrite) && wr_in_range;

  always_comb begin
    state_d = state_q;
    front_d = front_q;
    count_d = count_q;
    drop_d  = drop_q;
    unique case (state_q)
      StWrite: begin
        if (wr_new_frame_in) state_d = StWaitSwap;
      end
      StWaitSwap: begin
        if (wr_valid_in) drop_d = 1'b1;
        if (rd_vblank_in) begin
          state_d = StWrite;
          front_d = !front_q;
          count_d = count_q + 8'd1;
        end
      end
      default: state_d = StWrite;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= StWrite;
      front_q <= 1'b0;
      count_q <= 8'd0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      front_q <= front_d;
      count_q <= count_d;
      drop_q  <= drop_d;
    end
  end

  // Memory is never cleared; the back bank is the one not being displayed.
  always_ff @(posedge clk_in) begin
    if (wr_en) begin
      if (front_q) bank0_q[wr_addr] <= wr_color_in;
      else         bank1_q[wr_addr] <= wr_color_in;
    end
  end

  // Bank and address are captured together at the request edge, so a swap cannot corrupt data.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      rd_valid_q1 <= 1'b0;
      rd_data_q1  <= 4'd0;
      rd_valid_q2 <= 1'b0;
      rd_color_q2 <= 4'd0;
    end else begin
      rd_valid_q1 <= rd_valid_in;
      if (rd_valid_in && rd_in_range) rd_data_q1 <= front_q ? bank1_q[rd_addr] : bank0_q[rd_addr];
      else                            rd_data_q1 <= 4'd0;
      rd_valid_q2 <= rd_valid_q1;
      rd_color_q2 <= rd_valid_q1 ? rd_data_q1 : 4'd0;
    end
  end

  assign wr_ready_out    = (state_q == StWrite);
  assign rd_color_out    = rd_color_q2;
  assign rd_valid_out    = rd_valid_q2;
  assign front_sel_out   = front_q;
  assign frame_count_out = count_q;
  assign drop_out        = drop_q;

endmodule

// File: tb/tb_framebuffer_ctrl.sv
// Directed bench: a 4x2 instance for swap/read/drop behaviour and a 5x3 instance whose wider
// coordinate ports can express out-of-range pixels.
module tb_framebuffer_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // 4x2 instance
  logic [1:0] h = '0, rh = '0;
  logic       v = '0, rv = '0;
  logic [3:0] c = '0;
  logic       wv = 0, nf = 0, rdv = 0, vb = 0;
  logic       ready, rvo, fs, drop;
  logic [3:0] col;
  logic [7:0] fc;

  // 5x3 instance
  logic [2:0] h2 = '0, rh2 = '0;
  logic [1:0] v2 = '0, rv2 = '0;
  logic [3:0] c2 = '0;
  logic       wv2 = 0, nf2 = 0, rdv2 = 0, vb2 = 0;
  logic       ready2, rvo2, fs2, drop2;
  logic [3:0] col2;
  logic [7:0] fc2;

  int total = 0;
  int bad = 0;

  framebuffer_ctrl #(.DISPLAY_WIDTH(4), .DISPLAY_HEIGHT(2)) u_dut (
    .clk_in(clk), .rst_in(rst),
    .wr_hcount_in(h), .wr_vcount_in(v), .wr_color_in(c), .wr_valid_in(wv),
    .wr_new_frame_in(nf), .wr_ready_out(ready),
    .rd_hcount_in(rh), .rd_vcount_in(rv), .rd_valid_in(rdv), .rd_vblank_in(vb),
    .rd_color_out(col), .rd_valid_out(rvo), .front_sel_out(fs),
    .frame_count_out(fc), .drop_out(drop)
  );

  framebuffer_ctrl #(.DISPLAY_WIDTH(5), .DISPLAY_HEIGHT(3)) u_dut2 (
    .clk_in(clk), .rst_in(rst),
    .wr_hcount_in(h2), .wr_vcount_in(v2), .wr_color_in(c2), .wr_valid_in(wv2),
    .wr_new_frame_in(nf2), .wr_ready_out(ready2),
    .rd_hcount_in(rh2), .rd_vcount_in(rv2), .rd_valid_in(rdv2), .rd_vblank_in(vb2),
    .rd_color_out(col2), .rd_valid_out(rvo2), .front_sel_out(fs2),
    .frame_count_out(fc2), .drop_out(drop2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr1(input logic [1:0] hh, input logic vv, input logic [3:0] cc);
    h = hh; v = vv; c = cc; wv = 1'b1;
    tick();
    wv = 1'b0;
  endtask

  task automatic rd1(input logic [1:0] hh, input logic vv, input logic [3:0] exp, input string tag);
    rh = hh; rv = vv; rdv = 1'b1;
    tick();
    rdv = 1'b0;
    chk({tag, "_lat1"}, 32'(rvo), 32'd0);
    tick();
    chk({tag, "_valid"}, 32'(rvo), 32'd1);
    chk(tag, 32'(col), 32'(exp));
  endtask

  task automatic swap1();
    nf = 1'b1;
    tick();
    nf = 1'b0;
    vb = 1'b1;
    tick();
    vb = 1'b0;
  endtask

  task automatic wr2(input logic [2:0] hh, input logic [1:0] vv, input logic [3:0] cc);
    h2 = hh; v2 = vv; c2 = cc; wv2 = 1'b1;
    tick();
    wv2 = 1'b0;
  endtask

  task automatic rd2(input logic [2:0] hh, input logic [1:0] vv, input logic [3:0] exp,
                     input string tag);
    rh2 = hh; rv2 = vv; rdv2 = 1'b1;
    tick();
    rdv2 = 1'b0;
    tick();
    chk({tag, "_valid"}, 32'(rvo2), 32'd1);
    chk(tag, 32'(col2), 32'(exp));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_front", 32'(fs), 32'd0);
    chk("rst_count", 32'(fc), 32'd0);
    chk("rst_drop", 32'(drop), 32'd0);
    chk("rst_rvalid", 32'(rvo), 32'd0);
    chk("rst_rcolor", 32'(col), 32'd0);

    // Fill back bank (bank1) with color = address, then swap in vblank.
    for (int a = 0; a < 8; a++) wr1(2'(a % 4), 1'(a / 4), 4'(a));
    nf = 1'b1;
    tick();
    nf = 1'b0;
    chk("wait_ready", 32'(ready), 32'd0);
    chk("wait_front", 32'(fs), 32'd0);
    vb = 1'b1;
    tick();
    vb = 1'b0;
    chk("swap1_front", 32'(fs), 32'd1);
    chk("swap1_count", 32'(fc), 32'd1);
    chk("swap1_ready", 32'(ready), 32'd1);
    rd1(2'd3, 1'b1, 4'd7, "rd31");
    rd1(2'd1, 1'b0, 4'd1, "rd10");

    // Back bank is now bank0; a pixel arriving while waiting must be dropped.
    wr1(2'd0, 1'b0, 4'h3);
    nf = 1'b1;
    tick();
    nf = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        h = 2'd0; v = 1'b0; c = 4'hF; wv = 1'b1;
      end
      chk("wait10_ready", 32'(ready), 32'd0);
      tick();
      wv = 1'b0;
    end
    chk("drop_set", 32'(drop), 32'd1);
    vb = 1'b1;
    tick();
    vb = 1'b0;
    chk("swap2_front", 32'(fs), 32'd0);
    chk("swap2_count", 32'(fc), 32'd2);
    chk("drop_sticky", 32'(drop), 32'd1);
    rd1(2'd0, 1'b0, 4'h3, "rd00_nodrop");

    // Pixel on the same cycle as new_frame still lands in the old back bank.
    h = 2'd2; v = 1'b0; c = 4'hA; wv = 1'b1; nf = 1'b1;
    tick();
    wv = 1'b0; nf = 1'b0;
    chk("nfpix_ready", 32'(ready), 32'd0);
    vb = 1'b1;
    tick();
    vb = 1'b0;
    chk("swap3_front", 32'(fs), 32'd1);
    chk("swap3_count", 32'(fc), 32'd3);
    rd1(2'd2, 1'b0, 4'hA, "rd20_A");
    rd1(2'd3, 1'b1, 4'd7, "rd31_kept");

    // Read issued on the swap edge returns the old front bank.
    wr1(2'd3, 1'b1, 4'h5);
    nf = 1'b1;
    tick();
    nf = 1'b0;
    rh = 2'd3; rv = 1'b1; rdv = 1'b1; vb = 1'b1;
    tick();
    rdv = 1'b0; vb = 1'b0;
    chk("swap4_front", 32'(fs), 32'd0);
    chk("swap4_count", 32'(fc), 32'd4);
    tick();
    chk("inflight_valid", 32'(rvo), 32'd1);
    chk("inflight_old", 32'(col), 32'd7);
    tick();
    chk("idle_valid", 32'(rvo), 32'd0);
    chk("idle_color", 32'(col), 32'd0);
    rd1(2'd3, 1'b1, 4'h5, "rd31_new");

    // Reset both instances; memory survives.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst2_drop", 32'(drop), 32'd0);
    chk("rst2_count", 32'(fc), 32'd0);
    chk("rst2_front", 32'(fs), 32'd0);
    rd1(2'd3, 1'b1, 4'h5, "rd31_after_rst");
    rd1(2'd0, 1'b0, 4'h3, "rd00_after_rst");

    // Out-of-range coordinates on the 5x3 instance.
    wr2(3'd0, 2'd1, 4'h2);
    wr2(3'd4, 2'd2, 4'h9);
    wr2(3'd5, 2'd0, 4'hE);
    wr2(3'd0, 2'd3, 4'hE);
    wr2(3'd7, 2'd3, 4'hE);
    chk("oor_drop", 32'(drop2), 32'd0);
    chk("oor_ready", 32'(ready2), 32'd1);
    nf2 = 1'b1;
    tick();
    nf2 = 1'b0;
    vb2 = 1'b1;
    tick();
    vb2 = 1'b0;
    chk("oor_front", 32'(fs2), 32'd1);
    rd2(3'd0, 2'd1, 4'h2, "oor_alias01");
    rd2(3'd4, 2'd2, 4'h9, "oor_last");
    rd2(3'd5, 2'd0, 4'h0, "oor_rd50");
    rd2(3'd0, 2'd3, 4'h0, "oor_rd03");

    // Frame counter wrap.
    for (int i = 0; i < 255; i++) swap1();
    chk("cnt_255", 32'(fc), 32'd255);
    chk("cnt_255_front", 32'(fs), 32'd1);
    swap1();
    chk("cnt_wrap", 32'(fc), 32'd0);
    chk("cnt_wrap_front", 32'(fs), 32'd0);

    // Reset during WAIT_SWAP abandons the swap.
    nf = 1'b1;
    tick();
    nf = 1'b0;
    chk("pre_rst_ready", 32'(ready), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("wrst_ready", 32'(ready), 32'd1);
    chk("wrst_front", 32'(fs), 32'd0);
    vb = 1'b1;
    tick();
    vb = 1'b0;
    chk("wrst_noswap", 32'(fs), 32'd0);
    chk("wrst_count", 32'(fc), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
